// File: rtl/audio_dac_feeder.sv
// audio_dac_feeder: buffers signed PCM samples in a small FIFO and, on each
// sample-rate tick, scales one by a 4-bit volume, rounds, saturates and
// offset-encodes it for the sigma-delta DAC. Also divides CLK down into the
// DAC clock-enable strobe and keeps a sticky underrun flag.
module audio_dac_feeder #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 8,
    parameter int FIFO_AW = 2,
    parameter int CEN_DIV = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [IN_W-1:0]  in_sample,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sample_tick,
    input  logic [3:0]       volume,
    input  logic             underrun_clr,
    output logic [OUT_W-1:0] dac_sample,
    output logic             dac_cen,
    output logic             underrun
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int SH    = IN_W - OUT_W;
    localparam int CNT_W = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;

    localparam logic [FIFO_AW:0]          FULL_CNT = (FIFO_AW+1)'(DEPTH);
    localparam logic signed [IN_W+1:0]    RND      = (IN_W+2)'(1 << (SH-1));
    localparam logic signed [IN_W+1:0]    V_MAX    = (IN_W+2)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W+1:0]    V_MIN    = ~V_MAX;
    localparam logic [OUT_W-1:0]          MSB_MASK = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(CEN_DIV - 1);

    // FIFO storage has no reset so it can map onto RAM
    logic [IN_W-1:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]        count_q, count_d;
    logic                    push, pop;

    // Stage 1 holds the raw popped sample, stage 2 the volume-scaled value
    logic                    s1_valid_q, s1_valid_d;
    logic signed [IN_W-1:0]  s1_data_q, s1_data_d;
    logic                    s2_valid_q, s2_valid_d;
    logic signed [IN_W:0]    s2_data_q, s2_data_d;

    logic [OUT_W-1:0]        dac_q, dac_d;
    logic                    underrun_q, underrun_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    cen_q, cen_d;

    // Datapath intermediates
    logic [4:0]              gain;
    logic signed [IN_W+4:0]  s_ext, g_ext, prod;
    logic signed [IN_W+1:0]  rnd_sum, shifted, clamped;
    logic [OUT_W-1:0]        narrowed;

    assign in_ready   = (count_q != FULL_CNT);
    assign dac_sample = dac_q;
    assign dac_cen    = cen_q;
    assign underrun   = underrun_q;

    // FIFO write port: sample lands in RAM on an accepted handshake
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_sample;
        end
    end

    // FIFO pointers/count, pipeline stages, underrun flag and CEN divider
    always_comb begin
        push       = in_valid & in_ready;
        pop        = sample_tick & (count_q != '0);

        wr_ptr_d   = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + (FIFO_AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (FIFO_AW+1)'(1);
        end

        // Stage 1 capture: registered read of the FIFO head on a pop
        s1_valid_d = pop;
        s1_data_d  = pop ? $signed(mem_q[rd_ptr_q]) : s1_data_q;

        // Stage 1 -> 2: multiply by (volume+1), then divide by 16
        gain       = {1'b0, volume} + 5'd1;
        s_ext      = {{5{s1_data_q[IN_W-1]}}, s1_data_q};
        g_ext      = $signed({{IN_W{1'b0}}, gain});
        prod       = s_ext * g_ext;
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? (IN_W+1)'(prod >>> 4) : s2_data_q;

        // Stage 2 -> output: round half up, drop low bits, clamp, offset-encode
        rnd_sum    = $signed({s2_data_q[IN_W], s2_data_q}) + RND;
        shifted    = rnd_sum >>> SH;
        if (shifted > V_MAX) begin
            clamped = V_MAX;
        end else if (shifted < V_MIN) begin
            clamped = V_MIN;
        end else begin
            clamped = shifted;
        end
        narrowed   = OUT_W'(clamped);
        dac_d      = s2_valid_q ? (narrowed ^ MSB_MASK) : dac_q;

        // Sticky underrun; a new empty tick outranks a clear
        if (sample_tick && (count_q == '0)) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end

        // Free-running divider; strobe is registered so it is glitch-free
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        cen_d      = (cnt_d == CNT_LAST);
    end

    // State registers; reset drops queued and in-flight samples at once
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            dac_q      <= MSB_MASK;
            underrun_q <= 1'b0;
            cnt_q      <= '0;
            cen_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            dac_q      <= dac_d;
            underrun_q <= underrun_d;
            cnt_q      <= cnt_d;
            cen_q      <= cen_d;
        end
    end

endmodule

// File: tb/tb_audio_dac_feeder.sv
// Directed testbench for audio_dac_feeder. Inputs change on the falling
// edge; outputs are sampled on the falling edge, away from the active edge.
module tb_audio_dac_feeder;

    logic        CLK;
    logic        RESET;
    logic [15:0] in_sample;
    logic        in_valid;
    logic        in_ready;
    logic        sample_tick;
    logic [3:0]  volume;
    logic        underrun_clr;
    logic [7:0]  dac_sample;
    logic        dac_cen;
    logic        underrun;

    int vectors = 0;
    int errors  = 0;

    audio_dac_feeder #(
        .IN_W    (16),
        .OUT_W   (8),
        .FIFO_AW (2),
        .CEN_DIV (4)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .in_sample    (in_sample),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sample_tick  (sample_tick),
        .volume       (volume),
        .underrun_clr (underrun_clr),
        .dac_sample   (dac_sample),
        .dac_cen      (dac_cen),
        .underrun     (underrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stimulus only: push one sample, tick it out, wait until T+3
    task automatic run_one(input logic [15:0] s, input logic [3:0] v);
        volume    = v;
        in_sample = s;
        in_valid  = 1'b1;
        @(negedge CLK);
        in_valid    = 1'b0;
        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        logic exp_cen;
        vectors++;
        if (dac_sample !== 8'h80) begin
            errors++; $display("FAIL reset_dac: got %h want 80", dac_sample);
        end
        vectors++;
        if (underrun !== 1'b0) begin
            errors++; $display("FAIL reset_underrun: got %b want 0", underrun);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        RESET = 1'b0;
        #1;
        vectors++;
        if (dac_cen !== 1'b0) begin
            errors++; $display("FAIL cen_cycle0: got %b want 0", dac_cen);
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            exp_cen = ((k % 4) == 3);
            vectors++;
            if (dac_cen !== exp_cen) begin
                errors++; $display("FAIL cen_cycle%0d: got %b want %b", k, dac_cen, exp_cen);
            end
        end
        $display("reset: dac=%h underrun=%b in_ready=%b", dac_sample, underrun, in_ready);
    endtask

    task automatic test_conversion();
        volume    = 4'd15;
        in_sample = 16'h1234;
        in_valid  = 1'b1;
        @(negedge CLK);
        in_valid    = 1'b0;
        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        @(negedge CLK);
        vectors++;
        if (dac_sample !== 8'h80) begin
            errors++; $display("FAIL conv_latency_T2: got %h want 80", dac_sample);
        end
        @(negedge CLK);
        vectors++;
        if (dac_sample !== 8'h92) begin
            errors++; $display("FAIL conv_1234_v15: got %h want 92", dac_sample);
        end
        $display("conv: in=1234 vol=15 dac=%h", dac_sample);
        run_one(16'h0100, 4'd7);
        vectors++;
        if (dac_sample !== 8'h81) begin
            errors++; $display("FAIL conv_0100_v7: got %h want 81", dac_sample);
        end
        $display("conv: in=0100 vol=7 dac=%h", dac_sample);
        vectors++;
        if (underrun !== 1'b0) begin
            errors++; $display("FAIL conv_no_underrun: got %b want 0", underrun);
        end
    endtask

    task automatic test_saturation();
        run_one(16'h7FFF, 4'd15);
        vectors++;
        if (dac_sample !== 8'hFF) begin
            errors++; $display("FAIL sat_pos: got %h want ff", dac_sample);
        end
        $display("sat: in=7fff vol=15 dac=%h", dac_sample);
        run_one(16'h8000, 4'd15);
        vectors++;
        if (dac_sample !== 8'h00) begin
            errors++; $display("FAIL sat_neg: got %h want 00", dac_sample);
        end
        $display("sat: in=8000 vol=15 dac=%h", dac_sample);
        run_one(16'h7FFF, 4'd0);
        vectors++;
        if (dac_sample !== 8'h88) begin
            errors++; $display("FAIL vol0_7fff: got %h want 88", dac_sample);
        end
        $display("sat: in=7fff vol=0 dac=%h", dac_sample);
    endtask

    task automatic test_backpressure();
        logic [15:0] vals [5];
        int          accepted;
        logic        exp_rdy;
        logic [7:0]  exp_dac;
        for (int i = 0; i < 5; i++) vals[i] = 16'((i + 1) * 256);
        volume   = 4'd15;
        accepted = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_sample = vals[accepted];
            exp_rdy   = (accepted < 4);
            vectors++;
            if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL fill_ready_c%0d: got %b want %b", c, in_ready, exp_rdy);
            end
            if (exp_rdy) accepted++;
            @(negedge CLK);
        end
        $display("fill: accepted=%0d in_ready=%b", accepted, in_ready);
        in_sample = vals[4];
        vectors++;
        if (dac_sample !== 8'h88) begin
            errors++; $display("FAIL full_dac_hold: got %h want 88", dac_sample);
        end
        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_pop: got %b want 1", in_ready);
        end
        @(negedge CLK);
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL full_after_5th: got %b want 0", in_ready);
        end
        @(negedge CLK);
        vectors++;
        if (dac_sample !== 8'h81) begin
            errors++; $display("FAIL order_s0: got %h want 81", dac_sample);
        end
        $display("pop: dac=%h", dac_sample);
        // Four ticks on consecutive cycles drain the rest in order
        for (int i = 0; i < 7; i++) begin
            sample_tick = (i < 4);
            exp_dac     = (i < 3) ? 8'h81 : 8'(8'h82 + i - 3);
            vectors++;
            if (dac_sample !== exp_dac) begin
                errors++; $display("FAIL b2b_cycle%0d: got %h want %h", i, dac_sample, exp_dac);
            end
            $display("b2b: cycle=%0d dac=%h", i, dac_sample);
            @(negedge CLK);
        end
        sample_tick = 1'b0;
        vectors++;
        if (dac_sample !== 8'h85) begin
            errors++; $display("FAIL b2b_last: got %h want 85", dac_sample);
        end
        vectors++;
        if (underrun !== 1'b0) begin
            errors++; $display("FAIL b2b_no_underrun: got %b want 0", underrun);
        end
    endtask

    task automatic test_underrun();
        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        vectors++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL underrun_set: got %b want 1", underrun);
        end
        repeat (3) @(negedge CLK);
        vectors++;
        if (dac_sample !== 8'h85) begin
            errors++; $display("FAIL underrun_dac_hold: got %h want 85", dac_sample);
        end
        $display("underrun: flag=%b dac=%h", underrun, dac_sample);
        underrun_clr = 1'b1;
        sample_tick  = 1'b1;
        @(negedge CLK);
        underrun_clr = 1'b0;
        sample_tick  = 1'b0;
        vectors++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL set_wins_clr: got %b want 1", underrun);
        end
        underrun_clr = 1'b1;
        @(negedge CLK);
        underrun_clr = 1'b0;
        vectors++;
        if (underrun !== 1'b0) begin
            errors++; $display("FAIL clr_alone: got %b want 0", underrun);
        end
        $display("underrun_clr: flag=%b", underrun);
        // A push in the same cycle as an empty tick is not seen by that tick
        in_sample   = 16'h0600;
        in_valid    = 1'b1;
        sample_tick = 1'b1;
        @(negedge CLK);
        in_valid    = 1'b0;
        sample_tick = 1'b0;
        vectors++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL push_tick_underrun: got %b want 1", underrun);
        end
        repeat (2) @(negedge CLK);
        vectors++;
        if (dac_sample !== 8'h85) begin
            errors++; $display("FAIL push_tick_no_pop: got %h want 85", dac_sample);
        end
        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        repeat (2) @(negedge CLK);
        vectors++;
        if (dac_sample !== 8'h86) begin
            errors++; $display("FAIL push_tick_later_pop: got %h want 86", dac_sample);
        end
        $display("late pop: dac=%h", dac_sample);
        underrun_clr = 1'b1;
        @(negedge CLK);
        underrun_clr = 1'b0;
    endtask

    task automatic test_midstream_reset();
        volume   = 4'd15;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sample = 16'((i + 7) * 256);
            @(negedge CLK);
        end
        in_valid    = 1'b0;
        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        RESET = 1'b1;
        #1;
        vectors++;
        if (dac_sample !== 8'h80) begin
            errors++; $display("FAIL midrst_dac: got %h want 80", dac_sample);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_ready: got %b want 1", in_ready);
        end
        @(negedge CLK);
        RESET = 1'b0;
        sample_tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) sample_tick = 1'b0;
            @(negedge CLK);
            vectors++;
            if (dac_sample !== 8'h80) begin
                errors++; $display("FAIL midrst_stale_c%0d: got %h want 80", i, dac_sample);
            end
        end
        sample_tick = 1'b0;
        vectors++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL midrst_empty: got %b want 1", underrun);
        end
        $display("midrst: dac=%h underrun=%b", dac_sample, underrun);
        underrun_clr = 1'b1;
        @(negedge CLK);
        underrun_clr = 1'b0;
        run_one(16'h0B00, 4'd15);
        vectors++;
        if (dac_sample !== 8'h8B) begin
            errors++; $display("FAIL midrst_resume: got %h want 8b", dac_sample);
        end
        $display("midrst resume: dac=%h", dac_sample);
    endtask

    initial begin
        RESET        = 1'b1;
        in_sample    = '0;
        in_valid     = 1'b0;
        sample_tick  = 1'b0;
        volume       = 4'd15;
        underrun_clr = 1'b0;
        repeat (3) @(negedge CLK);
        test_reset();
        test_conversion();
        test_saturation();
        test_backpressure();
        test_underrun();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
